spi_slave_responder: RTL and testbench

- Mode-0 single-lane SPI slave: the far end of the PULPino SPI master.
- Deserialises each chip-select frame as CMD → ADDR → WDATA → DUMMY → RDATA, MSB first, and publishes cmd/addr/wdata as one packet.
- Serialises a supplied read word back on MISO.
- Used as the synthesizable responder model on the verification bench, and as the base of a register-mapped SPI peripheral.

---
 rtl/spi_slave_responder.sv | 244 ++++++++++++++++++++++++
 tb/tb_spi_slave_responder.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/spi_slave_responder.sv
// Mode-0 single-lane SPI slave: deserialises CMD/ADDR/WDATA/DUMMY/RDATA frames
// into a cmd/addr/wdata packet and serialises a supplied read word on MISO.
module spi_slave_responder #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned MAX_LEN     = 32
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               spi_sclk_i,
  input  logic               spi_csn_i,
  input  logic               spi_mosi_i,
  output logic               spi_miso_o,
  output logic               spi_miso_oe_o,
  input  logic [5:0]         cmd_len_i,
  input  logic [5:0]         addr_len_i,
  input  logic [5:0]         wdata_len_i,
  input  logic [5:0]         dummy_len_i,
  input  logic [5:0]         rdata_len_i,
  input  logic [MAX_LEN-1:0] rdata_i,
  output logic [MAX_LEN-1:0] cmd_o,
  output logic [MAX_LEN-1:0] addr_o,
  output logic [MAX_LEN-1:0] wdata_o,
  output logic               frame_valid_o,
  output logic               frame_err_o,
  output logic               busy_o
);

  localparam int unsigned LW = 6;
  localparam int unsigned DW = MAX_LEN;

  typedef enum logic [2:0] {
    IDLE_WAIT, IDLE, CMD, ADDR, WDATA, DUMMY, RDATA, DONE
  } state_t;

  state_t r_state, w_state_nx;

  logic [SYNC_STAGES-1:0] r_sclk_sync, r_csn_sync, r_mosi_sync;
  logic r_sclk_d, r_csn_d;
  logic w_sclk_s, w_csn_s, w_mosi_s;
  logic w_sclk_rise, w_sclk_fall, w_csn_rise, w_csn_fall;

  logic [LW-1:0] r_cmd_len, r_addr_len, r_wdata_len, r_dummy_len, r_rdata_len;
  logic [LW-1:0] w_cmd_len, w_addr_len, w_wdata_len, w_dummy_len, w_rdata_len;
  logic [LW-1:0] r_bit_cnt, w_cnt_nx, w_cnt_inc, w_cur_len;

  logic [DW-1:0] r_cmd_sh, r_addr_sh, r_wdata_sh, r_tx_sh;
  logic [DW-1:0] w_cmd_nx, w_addr_nx, w_wdata_nx;
  logic [DW-1:0] r_cmd_out, r_addr_out, r_wdata_out;
  logic r_frame_valid, r_frame_err, r_busy, r_miso, r_miso_oe;
  logic w_frame_start, w_frame_ok, w_frame_err, w_busy_nx, w_enter_rdata;

  function automatic logic [LW-1:0] clamp_len(input logic [LW-1:0] len);
    return (len > LW'(MAX_LEN)) ? LW'(MAX_LEN) : len;
  endfunction

  // Earliest later phase with a non-zero length wins; DONE when none remain.
  function automatic state_t next_phase(input state_t cur,
                                        input logic [LW-1:0] l_cmd, l_addr, l_wdata,
                                        input logic [LW-1:0] l_dummy, l_rdata);
    state_t nx;
    nx = DONE;
    if ((cur inside {IDLE, CMD, ADDR, WDATA, DUMMY}) && (l_rdata != '0)) nx = RDATA;
    if ((cur inside {IDLE, CMD, ADDR, WDATA}) && (l_dummy != '0)) nx = DUMMY;
    if ((cur inside {IDLE, CMD, ADDR}) && (l_wdata != '0)) nx = WDATA;
    if ((cur inside {IDLE, CMD}) && (l_addr != '0)) nx = ADDR;
    if ((cur == IDLE) && (l_cmd != '0)) nx = CMD;
    return nx;
  endfunction

  assign w_sclk_s    = r_sclk_sync[SYNC_STAGES-1];
  assign w_csn_s     = r_csn_sync[SYNC_STAGES-1];
  assign w_mosi_s    = r_mosi_sync[SYNC_STAGES-1];
  assign w_sclk_rise = w_sclk_s & ~r_sclk_d;
  assign w_sclk_fall = ~w_sclk_s & r_sclk_d;
  assign w_csn_rise  = w_csn_s & ~r_csn_d;
  assign w_csn_fall  = ~w_csn_s & r_csn_d;

  assign w_cmd_len   = clamp_len(cmd_len_i);
  assign w_addr_len  = clamp_len(addr_len_i);
  assign w_wdata_len = clamp_len(wdata_len_i);
  assign w_dummy_len = clamp_len(dummy_len_i);
  assign w_rdata_len = clamp_len(rdata_len_i);
  assign w_cnt_inc   = r_bit_cnt + LW'(1);

  // Synchronisers reset low so a held-low CSn is never mistaken for a new frame.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_sclk_sync <= '0;
      r_csn_sync  <= '0;
      r_mosi_sync <= '0;
      r_sclk_d    <= 1'b0;
      r_csn_d     <= 1'b0;
    end else begin
      r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], spi_sclk_i};
      r_csn_sync  <= {r_csn_sync[SYNC_STAGES-2:0], spi_csn_i};
      r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], spi_mosi_i};
      r_sclk_d    <= w_sclk_s;
      r_csn_d     <= w_csn_s;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) r_state <= IDLE_WAIT;
    else       r_state <= w_state_nx;
  end

  // Next state, bit counting and shifter updates; the bit is taken before end-of-frame.
  always_comb begin
    w_state_nx    = r_state;
    w_cnt_nx      = r_bit_cnt;
    w_cur_len     = '0;
    w_frame_start = 1'b0;
    w_frame_ok    = 1'b0;
    w_frame_err   = 1'b0;
    w_cmd_nx      = r_cmd_sh;
    w_addr_nx     = r_addr_sh;
    w_wdata_nx    = r_wdata_sh;

    case (r_state)
      CMD:     w_cur_len = r_cmd_len;
      ADDR:    w_cur_len = r_addr_len;
      WDATA:   w_cur_len = r_wdata_len;
      DUMMY:   w_cur_len = r_dummy_len;
      RDATA:   w_cur_len = r_rdata_len;
      default: w_cur_len = '0;
    endcase

    case (r_state)
      IDLE_WAIT: if (w_csn_s) w_state_nx = IDLE;
      IDLE: begin
        if (w_csn_fall) begin
          w_frame_start = 1'b1;
          w_cnt_nx      = '0;
          w_cmd_nx      = '0;
          w_addr_nx     = '0;
          w_wdata_nx    = '0;
          w_state_nx    = next_phase(IDLE, w_cmd_len, w_addr_len, w_wdata_len,
                                     w_dummy_len, w_rdata_len);
        end
      end
      CMD, ADDR, WDATA, DUMMY, RDATA: begin
        if (w_sclk_rise) begin
          if (r_state == CMD)   w_cmd_nx   = {r_cmd_sh[DW-2:0], w_mosi_s};
          if (r_state == ADDR)  w_addr_nx  = {r_addr_sh[DW-2:0], w_mosi_s};
          if (r_state == WDATA) w_wdata_nx = {r_wdata_sh[DW-2:0], w_mosi_s};
          if (w_cnt_inc == w_cur_len) begin
            w_cnt_nx   = '0;
            w_state_nx = next_phase(r_state, r_cmd_len, r_addr_len, r_wdata_len,
                                    r_dummy_len, r_rdata_len);
          end else begin
            w_cnt_nx = w_cnt_inc;
          end
        end
      end
      default: ;
    endcase

    if ((r_state != IDLE_WAIT) && (r_state != IDLE) && w_csn_rise) begin
      if (w_state_nx == DONE) w_frame_ok = 1'b1;
      else                    w_frame_err = 1'b1;
      w_state_nx = IDLE;
    end
  end

  assign w_busy_nx     = (w_state_nx != IDLE_WAIT) && (w_state_nx != IDLE);
  assign w_enter_rdata = (w_state_nx == RDATA) && (r_state != RDATA);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_cmd_len     <= '0;
      r_addr_len    <= '0;
      r_wdata_len   <= '0;
      r_dummy_len   <= '0;
      r_rdata_len   <= '0;
      r_bit_cnt     <= '0;
      r_cmd_sh      <= '0;
      r_addr_sh     <= '0;
      r_wdata_sh    <= '0;
      r_cmd_out     <= '0;
      r_addr_out    <= '0;
      r_wdata_out   <= '0;
      r_frame_valid <= 1'b0;
      r_frame_err   <= 1'b0;
      r_busy        <= 1'b0;
    end else begin
      if (w_frame_start) begin
        r_cmd_len   <= w_cmd_len;
        r_addr_len  <= w_addr_len;
        r_wdata_len <= w_wdata_len;
        r_dummy_len <= w_dummy_len;
        r_rdata_len <= w_rdata_len;
      end
      r_bit_cnt  <= w_cnt_nx;
      r_cmd_sh   <= w_cmd_nx;
      r_addr_sh  <= w_addr_nx;
      r_wdata_sh <= w_wdata_nx;
      if (w_frame_ok) begin
        r_cmd_out   <= w_cmd_nx;
        r_addr_out  <= w_addr_nx;
        r_wdata_out <= w_wdata_nx;
      end
      r_frame_valid <= w_frame_ok;
      r_frame_err   <= w_frame_err;
      r_busy        <= w_busy_nx;
    end
  end

  // MISO: MSB on entry when RDATA opens the frame, otherwise on the next SCLK fall.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_tx_sh   <= '0;
      r_miso    <= 1'b0;
      r_miso_oe <= 1'b0;
    end else if (w_csn_rise) begin
      r_miso    <= 1'b0;
      r_miso_oe <= 1'b0;
    end else if (w_enter_rdata && (r_state == IDLE)) begin
      r_tx_sh   <= rdata_i << 1;
      r_miso    <= rdata_i[DW-1];
      r_miso_oe <= 1'b1;
    end else if (w_enter_rdata) begin
      r_tx_sh <= rdata_i;
    end else if (w_sclk_fall) begin
      if (r_state == RDATA) begin
        r_miso    <= r_tx_sh[DW-1];
        r_tx_sh   <= r_tx_sh << 1;
        r_miso_oe <= 1'b1;
      end else begin
        r_miso    <= 1'b0;
        r_miso_oe <= 1'b0;
      end
    end
  end

  assign spi_miso_o    = r_miso;
  assign spi_miso_oe_o = r_miso_oe;
  assign cmd_o         = r_cmd_out;
  assign addr_o        = r_addr_out;
  assign wdata_o       = r_wdata_out;
  assign frame_valid_o = r_frame_valid;
  assign frame_err_o   = r_frame_err;
  assign busy_o        = r_busy;

endmodule

// File: tb/tb_spi_slave_responder.sv
// Directed bench for spi_slave_responder: a table of frames plus hand-written
// read-back and mid-frame-reset sequences.
module tb_spi_slave_responder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        sclk = 1'b0;
  logic        csn = 1'b1;
  logic        mosi = 1'b0;
  logic        miso, miso_oe;
  logic [5:0]  cmd_len = '0, addr_len = '0, wdata_len = '0, dummy_len = '0, rdata_len = '0;
  logic [31:0] rdata = '0;
  logic [31:0] cmd_q, addr_q, wdata_q;
  logic        fvalid, ferr, busy;

  int n_checks = 0;
  int n_errors = 0;
  int n_valid_seen = 0;
  int n_err_seen = 0;
  int n_oe_seen = 0;

  spi_slave_responder #(.SYNC_STAGES(2), .MAX_LEN(32)) dut (
    .clk_i(clk), .rst_i(rst),
    .spi_sclk_i(sclk), .spi_csn_i(csn), .spi_mosi_i(mosi),
    .spi_miso_o(miso), .spi_miso_oe_o(miso_oe),
    .cmd_len_i(cmd_len), .addr_len_i(addr_len), .wdata_len_i(wdata_len),
    .dummy_len_i(dummy_len), .rdata_len_i(rdata_len), .rdata_i(rdata),
    .cmd_o(cmd_q), .addr_o(addr_q), .wdata_o(wdata_q),
    .frame_valid_o(fvalid), .frame_err_o(ferr), .busy_o(busy)
  );

  always #5 clk = ~clk;

  // Pulse and oe activity counters, sampled mid-cycle.
  always @(negedge clk) begin
    if (fvalid)  n_valid_seen <= n_valid_seen + 1;
    if (ferr)    n_err_seen   <= n_err_seen + 1;
    if (miso_oe) n_oe_seen    <= n_oe_seen + 1;
  end

  typedef struct {
    logic [5:0]   l_cmd, l_addr, l_wdata;
    logic [127:0] bits;
    int           nbits, half, gap;
    int           exp_valid, exp_err;
    logic [31:0]  exp_cmd, exp_addr, exp_wdata;
  } vec_t;

  vec_t vecs[6];

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Clocks n bits MSB first; MISO/OE are captured just before each rising edge.
  task automatic spi_bits(input logic [127:0] bits, input int n, input int h,
                          output logic [127:0] miso_v, output logic [127:0] oe_v);
    miso_v = '0;
    oe_v   = '0;
    for (int i = n - 1; i >= 0; i--) begin
      mosi = bits[i];
      tick(h);
      miso_v[i] = miso;
      oe_v[i]   = miso_oe;
      sclk = 1'b1;
      tick(h);
      sclk = 1'b0;
    end
  endtask

  task automatic run_frame(input logic [127:0] bits, input int n, input int h, input int gap,
                           output logic [127:0] miso_v, output logic [127:0] oe_v);
    csn = 1'b0;
    tick(h);
    spi_bits(bits, n, h, miso_v, oe_v);
    tick(h);
    csn = 1'b1;
    tick(gap);
  endtask

  initial begin
    logic [127:0] mv, ov;
    int v0, e0, o0;

    vecs[0] = '{6'd8, 6'd24, 6'd32, 128'h0200ABCDDEADBEEF, 64, 4, 8, 1, 0,
                32'h02, 32'h00ABCD, 32'hDEADBEEF};
    vecs[1] = '{6'd8, 6'd24, 6'd32, 128'h0200A, 20, 4, 8, 0, 1,
                32'h02, 32'h00ABCD, 32'hDEADBEEF};
    vecs[2] = '{6'd40, 6'd0, 6'd0, 128'hFFFF0000FF, 40, 4, 8, 1, 0,
                32'hFFFF0000, 32'h0, 32'h0};
    vecs[3] = '{6'd0, 6'd0, 6'd0, 128'h0, 0, 4, 8, 1, 0,
                32'h0, 32'h0, 32'h0};
    vecs[4] = '{6'd8, 6'd8, 6'd0, 128'h5A3C, 16, 2, 4, 1, 0,
                32'h5A, 32'h3C, 32'h0};
    vecs[5] = '{6'd8, 6'd8, 6'd0, 128'hC381, 16, 2, 4, 1, 0,
                32'hC3, 32'h81, 32'h0};

    tick(4);
    check("reset_cmd", 64'(cmd_q), 64'h0);
    check("reset_addr", 64'(addr_q), 64'h0);
    check("reset_wdata", 64'(wdata_q), 64'h0);
    check("reset_flags", {60'h0, fvalid, ferr, busy, miso_oe}, 64'h0);
    check("reset_miso", 64'(miso), 64'h0);
    rst = 1'b0;
    tick(6);

    for (int i = 0; i < 6; i++) begin
      cmd_len = vecs[i].l_cmd;   addr_len = vecs[i].l_addr;   wdata_len = vecs[i].l_wdata;
      dummy_len = '0;            rdata_len = '0;              rdata = '0;
      v0 = n_valid_seen; e0 = n_err_seen; o0 = n_oe_seen;
      run_frame(vecs[i].bits, vecs[i].nbits, vecs[i].half, vecs[i].gap, mv, ov);
      check($sformatf("v%0d_valid", i), 64'(n_valid_seen - v0), 64'(vecs[i].exp_valid));
      check($sformatf("v%0d_err", i),   64'(n_err_seen - e0),   64'(vecs[i].exp_err));
      check($sformatf("v%0d_oe", i),    64'(n_oe_seen - o0),    64'h0);
      check($sformatf("v%0d_cmd", i),   64'(cmd_q),   64'(vecs[i].exp_cmd));
      check($sformatf("v%0d_addr", i),  64'(addr_q),  64'(vecs[i].exp_addr));
      check($sformatf("v%0d_wdata", i), 64'(wdata_q), 64'(vecs[i].exp_wdata));
      check($sformatf("v%0d_busy", i),  64'(busy),    64'h0);
    end

    // Read frame: 20 bits of cmd/addr/dummy, then 16 bits of read data on MISO.
    cmd_len = 6'd8; addr_len = 6'd8; wdata_len = 6'd0; dummy_len = 6'd4; rdata_len = 6'd16;
    rdata = 32'hA5C3_0000;
    v0 = n_valid_seen; e0 = n_err_seen;
    csn = 1'b0;
    tick(4);
    check("rd_busy", 64'(busy), 64'h1);
    spi_bits(128'h0B1000000, 36, 4, mv, ov);
    tick(4);
    check("rd_oe_tail", 64'(miso_oe), 64'h0);
    csn = 1'b1;
    tick(8);
    check("rd_miso", 64'(mv[15:0]), 64'hA5C3);
    check("rd_oe_window", 64'(ov[35:0]), 64'h0_0000_FFFF);
    check("rd_valid", 64'(n_valid_seen - v0), 64'h1);
    check("rd_err", 64'(n_err_seen - e0), 64'h0);
    check("rd_cmd", 64'(cmd_q), 64'h0B);
    check("rd_addr", 64'(addr_q), 64'h10);
    check("rd_wdata", 64'(wdata_q), 64'h0);

    // Reset at bit 10: outputs clear, the rest of the frame raises no pulse.
    cmd_len = 6'd8; addr_len = 6'd8; dummy_len = 6'd0; rdata_len = 6'd0; rdata = '0;
    v0 = n_valid_seen; e0 = n_err_seen;
    csn = 1'b0;
    tick(4);
    spi_bits(128'h048, 10, 4, mv, ov);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    check("rst_cmd", 64'(cmd_q), 64'h0);
    check("rst_addr", 64'(addr_q), 64'h0);
    check("rst_busy", 64'(busy), 64'h0);
    spi_bits(128'h34, 6, 4, mv, ov);
    tick(4);
    csn = 1'b1;
    tick(8);
    check("rst_no_valid", 64'(n_valid_seen - v0), 64'h0);
    check("rst_no_err", 64'(n_err_seen - e0), 64'h0);
    check("rst_cmd_after", 64'(cmd_q), 64'h0);

    cmd_len = 6'd8; addr_len = 6'd0;
    v0 = n_valid_seen;
    run_frame(128'h9F, 8, 4, 8, mv, ov);
    check("post_rst_valid", 64'(n_valid_seen - v0), 64'h1);
    check("post_rst_cmd", 64'(cmd_q), 64'h9F);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
